// File: rtl/register_file_pkg.sv
// Shared LEGv8 register-file definitions: index width, data width and the XZR index.
// Also used by the control decoder and the ALU-side muxes.
package register_file_pkg;

  localparam int unsigned RegIdxW = 5;
  localparam int unsigned DataW   = 64;
  localparam logic [RegIdxW-1:0] Xzr = 5'd31;

endpackage

// File: rtl/register_file_reg_read_port.sv
// One combinational read port: XZR forcing, reset masking and optional same-cycle write bypass.
// Both read ports instance this module.
module reg_read_port
  import register_file_pkg::*;
#(
  parameter int unsigned n      = DataW,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic [RegIdxW-1:0] idx,
  input  logic [n-1:0]       mem [NREG],
  input  logic               reset,
  input  logic               wrEn,
  input  logic [RegIdxW-1:0] wrIdx,
  input  logic [n-1:0]       wrData,
  output logic [n-1:0]       data
);

  always_comb begin
    data = '0;
    // XZR and reset both force zero; the write is blocked under reset, so is its bypass.
    if (!reset && idx != Xzr) begin
      if (BYPASS != 0 && wrEn && wrIdx == idx) begin
        data = wrData;
      end else begin
        data = mem[idx];
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports, one clocked write port.
// X31 is XZR; asynchronous active-high reset clears every entry.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned n      = DataW,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [RegIdxW-1:0] RA,
  input  logic [RegIdxW-1:0] RB,
  input  logic [RegIdxW-1:0] RW,
  input  logic [n-1:0]       BusW,
  input  logic               RegWr,
  output logic [n-1:0]       BusA,
  output logic [n-1:0]       BusB
);

  logic [n-1:0] mem [NREG];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem[i] <= '0;
      end
    end else if (RegWr && RW != Xzr) begin
      mem[RW] <= BusW;
    end
  end

  reg_read_port #(
    .n      (n),
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) portA (
    .idx    (RA),
    .mem    (mem),
    .reset  (Reset),
    .wrEn   (RegWr),
    .wrIdx  (RW),
    .wrData (BusW),
    .data   (BusA)
  );

  reg_read_port #(
    .n      (n),
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) portB (
    .idx    (RB),
    .mem    (mem),
    .reset  (Reset),
    .wrEn   (RegWr),
    .wrIdx  (RW),
    .wrData (BusW),
    .data   (BusB)
  );

endmodule
